// File: rtl/intc_prio_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | intc_prio_arb : multi-source interrupt controller, fixed-priority arbiter  |
// |                 with per-CPU threshold, NMI and req/ack handshake.         |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module intc_prio_arb #(
    parameter int          SRC_NUM  = 32,
    parameter int          CPU_NUM  = 1,
    parameter int          PRIO_W   = 4,
    parameter logic [7:0]  VEC_BASE = 8'h40,
    parameter logic [7:0]  NMI_VEC  = 8'h0B
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SRC_NUM-1:0]        intreq_i,
    input  logic [CPU_NUM-1:0]        intreq_nmi_i,
    input  logic                      bs_sel_i,
    input  logic                      bs_wr_i,
    input  logic [11:0]               bs_addr_i,
    input  logic [31:0]               bs_wdata_i,
    output logic [31:0]               bs_rdata_o,
    output logic [CPU_NUM-1:0]        intr_req_o,
    output logic [CPU_NUM-1:0][4:0]   intr_level_o,
    output logic [CPU_NUM-1:0][7:0]   intr_vec_o,
    input  logic [CPU_NUM-1:0]        inta_ack_i
);

    localparam int IDX_W = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    logic [SRC_NUM-1:0] req_s1_q, req_s2_q, req_s3_q;
    logic [SRC_NUM-1:0] ie_q, idt_q, pend_q, pend_d;
    logic [SRC_NUM-1:0] w_sint, w_w1c, w_ack_clr;
    logic [CPU_NUM-1:0] nmi_s1_q, nmi_s2_q, nmi_s3_q, nmi_pend_q, nmi_pend_d;
    logic [PRIO_W-1:0]  prio_q [SRC_NUM];
    logic [2:0]         tgt_q  [SRC_NUM];
    logic [3:0]         thr_q  [CPU_NUM];
    logic [31:0]        rdata_q, w_rdata;

    state_t             state_q [CPU_NUM];
    state_t             state_d [CPU_NUM];
    logic [7:0]         vec_q [CPU_NUM], vec_d [CPU_NUM];
    logic [4:0]         lvl_q [CPU_NUM], lvl_d [CPU_NUM];
    logic [IDX_W-1:0]   idx_q [CPU_NUM], idx_d [CPU_NUM];
    logic [CPU_NUM-1:0] nmi_shown_q, nmi_shown_d;

    logic [CPU_NUM-1:0] w_win_vld;
    logic [IDX_W-1:0]   w_win_idx  [CPU_NUM];
    logic [PRIO_W-1:0]  w_win_prio [CPU_NUM];

    logic [9:0] w_word;
    logic       w_wr, w_rd, w_addr_unused;

    assign w_word        = bs_addr_i[11:2];
    assign w_wr          = bs_sel_i & bs_wr_i;
    assign w_rd          = bs_sel_i & ~bs_wr_i;
    assign w_addr_unused = ^bs_addr_i[1:0];

    // Bus decode for the bitmap registers and read mux.
    always_comb begin
        w_sint  = '0;
        w_w1c   = '0;
        w_rdata = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            w_sint[i] = w_wr && (w_word == 10'(48 + i / 32)) && bs_wdata_i[i % 32];
            w_w1c[i]  = w_wr && (w_word == 10'(32 + i / 32)) && bs_wdata_i[i % 32];
            if (w_word == 10'(i / 32))      w_rdata[i % 32] = ie_q[i];
            if (w_word == 10'(16 + i / 32)) w_rdata[i % 32] = idt_q[i];
            if (w_word == 10'(32 + i / 32)) w_rdata[i % 32] = pend_q[i];
            if (w_word == 10'(64 + i)) begin
                w_rdata[PRIO_W-1:0] = prio_q[i];
                w_rdata[18:16]      = tgt_q[i];
            end
        end
        for (int c = 0; c < CPU_NUM; c++) begin
            if (w_word == 10'(512 + c)) w_rdata[3:0] = thr_q[c];
        end
    end

    // An ack retires exactly the source that was on the outputs that cycle.
    always_comb begin
        w_ack_clr  = '0;
        nmi_pend_d = nmi_pend_q;
        for (int c = 0; c < CPU_NUM; c++) begin
            if (state_q[c] == ST_REQ && inta_ack_i[c]) begin
                if (nmi_shown_q[c]) nmi_pend_d[c] = 1'b0;
                else                w_ack_clr[idx_q[c]] = 1'b1;
            end
            if (nmi_s2_q[c] && !nmi_s3_q[c]) nmi_pend_d[c] = 1'b1;
        end
    end

    // Set beats clear; level sources simply follow their synchronised input.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < SRC_NUM; i++) begin
            if (idt_q[i]) begin
                if ((req_s2_q[i] && !req_s3_q[i]) || w_sint[i]) pend_d[i] = 1'b1;
                else if (w_w1c[i] || w_ack_clr[i])              pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = req_s2_q[i];
            end
        end
    end

    // Strict '>' keeps the lowest index on a priority tie.
    always_comb begin
        for (int c = 0; c < CPU_NUM; c++) begin
            w_win_vld[c]  = 1'b0;
            w_win_idx[c]  = '0;
            w_win_prio[c] = '0;
            for (int i = 0; i < SRC_NUM; i++) begin
                if (pend_q[i] && ie_q[i] && (tgt_q[i] == 3'(c)) &&
                    (4'(prio_q[i]) > thr_q[c]) && (prio_q[i] > w_win_prio[c])) begin
                    w_win_vld[c]  = 1'b1;
                    w_win_idx[c]  = IDX_W'(i);
                    w_win_prio[c] = prio_q[i];
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CPU_NUM; c++) begin
            state_d[c]     = state_q[c];
            vec_d[c]       = '0;
            lvl_d[c]       = '0;
            idx_d[c]       = idx_q[c];
            nmi_shown_d[c] = 1'b0;
            case (state_q[c])
                ST_IDLE, ST_REQ: begin
                    if (state_q[c] == ST_REQ && inta_ack_i[c]) begin
                        state_d[c] = ST_GAP;
                    end else if (nmi_pend_q[c]) begin
                        state_d[c]     = ST_REQ;
                        vec_d[c]       = NMI_VEC;
                        lvl_d[c]       = 5'd16;
                        nmi_shown_d[c] = 1'b1;
                    end else if (w_win_vld[c]) begin
                        state_d[c] = ST_REQ;
                        vec_d[c]   = VEC_BASE + 8'(w_win_idx[c]);
                        lvl_d[c]   = 5'(w_win_prio[c]);
                        idx_d[c]   = w_win_idx[c];
                    end else begin
                        state_d[c] = ST_IDLE;
                    end
                end
                ST_GAP:  state_d[c] = ST_IDLE;
                default: state_d[c] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s1_q    <= '0;
            req_s2_q    <= '0;
            req_s3_q    <= '0;
            nmi_s1_q    <= '0;
            nmi_s2_q    <= '0;
            nmi_s3_q    <= '0;
            ie_q        <= '0;
            idt_q       <= '0;
            pend_q      <= '0;
            nmi_pend_q  <= '0;
            nmi_shown_q <= '0;
            rdata_q     <= '0;
            for (int i = 0; i < SRC_NUM; i++) begin
                prio_q[i] <= '0;
                tgt_q[i]  <= '0;
            end
            for (int c = 0; c < CPU_NUM; c++) begin
                thr_q[c]   <= '0;
                state_q[c] <= ST_IDLE;
                vec_q[c]   <= '0;
                lvl_q[c]   <= '0;
                idx_q[c]   <= '0;
            end
        end else begin
            req_s1_q    <= intreq_i;
            req_s2_q    <= req_s1_q;
            req_s3_q    <= req_s2_q;
            nmi_s1_q    <= intreq_nmi_i;
            nmi_s2_q    <= nmi_s1_q;
            nmi_s3_q    <= nmi_s2_q;
            pend_q      <= pend_d;
            nmi_pend_q  <= nmi_pend_d;
            nmi_shown_q <= nmi_shown_d;
            rdata_q     <= w_rd ? w_rdata : 32'd0;
            for (int i = 0; i < SRC_NUM; i++) begin
                if (w_wr && w_word == 10'(i / 32))      ie_q[i]  <= bs_wdata_i[i % 32];
                if (w_wr && w_word == 10'(16 + i / 32)) idt_q[i] <= bs_wdata_i[i % 32];
                if (w_wr && w_word == 10'(64 + i)) begin
                    prio_q[i] <= bs_wdata_i[PRIO_W-1:0];
                    tgt_q[i]  <= bs_wdata_i[18:16];
                end
            end
            for (int c = 0; c < CPU_NUM; c++) begin
                if (w_wr && w_word == 10'(512 + c)) thr_q[c] <= bs_wdata_i[3:0];
                state_q[c] <= state_d[c];
                vec_q[c]   <= vec_d[c];
                lvl_q[c]   <= lvl_d[c];
                idx_q[c]   <= idx_d[c];
            end
        end
    end

    assign bs_rdata_o = rdata_q;

    generate
        for (genvar c = 0; c < CPU_NUM; c++) begin : g_cpu_out
            assign intr_req_o[c]   = (state_q[c] == ST_REQ);
            assign intr_level_o[c] = lvl_q[c];
            assign intr_vec_o[c]   = vec_q[c];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_intc_prio_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_intc_prio_arb : directed self-checking bench for intc_prio_arb          |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_intc_prio_arb;

    localparam int SRC = 32;
    localparam int CPU = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [SRC-1:0]        intreq;
    logic [CPU-1:0]        nmi, ack;
    logic                  sel, wr;
    logic [11:0]           addr;
    logic [31:0]           wdata, rdata;
    logic [CPU-1:0]        req;
    logic [CPU-1:0][4:0]   level;
    logic [CPU-1:0][7:0]   vec;
    logic [31:0]           d;

    int n_pass = 0;
    int n_chk  = 0;

    intc_prio_arb #(.SRC_NUM(SRC), .CPU_NUM(CPU), .PRIO_W(4),
                    .VEC_BASE(8'h40), .NMI_VEC(8'h0B)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .intreq_i     (intreq),
        .intreq_nmi_i (nmi),
        .bs_sel_i     (sel),
        .bs_wr_i      (wr),
        .bs_addr_i    (addr),
        .bs_wdata_i   (wdata),
        .bs_rdata_o   (rdata),
        .intr_req_o   (req),
        .intr_level_o (level),
        .intr_vec_o   (vec),
        .inta_ack_i   (ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [11:0] a, input logic [31:0] v);
        sel = 1'b1; wr = 1'b1; addr = a; wdata = v;
        tick();
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [11:0] a, output logic [31:0] v);
        sel = 1'b1; wr = 1'b0; addr = a;
        tick();
        sel = 1'b0;
        v = rdata;
    endtask

    task automatic wait_req(input int c, input int budget);
        for (int i = 0; i < budget && !req[c]; i++) tick();
    endtask

    task automatic do_ack(input int c);
        ack[c] = 1'b1;
        tick();
        ack[c] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; intreq = '1; nmi = '0; ack = '0;
        sel = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) tick();
        n_chk++; if (req !== 2'b00) $display("FAIL rst_req got=%b exp=00", req); else n_pass++;
        n_chk++; if (level !== 10'd0) $display("FAIL rst_level got=%h exp=0", level); else n_pass++;
        n_chk++; if (vec !== 16'd0) $display("FAIL rst_vec got=%h exp=0", vec); else n_pass++;
        n_chk++; if (rdata !== 32'd0) $display("FAIL rst_rdata got=%h exp=0", rdata); else n_pass++;
        rst_n = 1'b1;
        repeat (10) tick();
        n_chk++; if (req !== 2'b00) $display("FAIL rst_ie0_req got=%b exp=00", req); else n_pass++;
        bus_rd(12'h000, d);
        n_chk++; if (d !== 32'd0) $display("FAIL rst_ie_rd got=%h exp=0", d); else n_pass++;
        intreq = '0;
        repeat (5) tick();
    endtask

    task automatic test_latency();
        bus_wr(12'h10C, 32'd5);
        bus_wr(12'h040, 32'h0000_0008);
        bus_wr(12'h000, 32'h0000_0008);
        intreq[3] = 1'b1;
        tick();                // edge N samples the rise
        tick(); tick();        // N+1, N+2
        n_chk++; if (req[0] !== 1'b0) $display("FAIL lat_early got=%b exp=0", req[0]); else n_pass++;
        tick();                // N+3
        n_chk++; if (req[0] !== 1'b1) $display("FAIL lat_req got=%b exp=1", req[0]); else n_pass++;
        n_chk++; if (level[0] !== 5'd5) $display("FAIL lat_level got=%0d exp=5", level[0]); else n_pass++;
        n_chk++; if (vec[0] !== 8'h43) $display("FAIL lat_vec got=%h exp=43", vec[0]); else n_pass++;
        do_ack(0);
        n_chk++; if (req[0] !== 1'b0) $display("FAIL lat_gap got=%b exp=0", req[0]); else n_pass++;
        bus_rd(12'h080, d);
        n_chk++; if (d[3] !== 1'b0) $display("FAIL lat_pend3 got=%b exp=0", d[3]); else n_pass++;
        intreq[3] = 1'b0;
    endtask

    task automatic test_prio_tie();
        bus_wr(12'h000, 32'd0);
        bus_wr(12'h108, 32'd4);
        bus_wr(12'h11C, 32'd9);
        bus_wr(12'h124, 32'd9);
        bus_wr(12'h040, 32'h0000_028C);
        bus_wr(12'h000, 32'h0000_0284);
        intreq[2] = 1'b1; intreq[7] = 1'b1; intreq[9] = 1'b1;
        wait_req(0, 10);
        n_chk++; if (req[0] !== 1'b1 || vec[0] !== 8'h47) $display("FAIL tie_first got=%b/%h exp=1/47", req[0], vec[0]); else n_pass++;
        n_chk++; if (level[0] !== 5'd9) $display("FAIL tie_level got=%0d exp=9", level[0]); else n_pass++;
        do_ack(0);
        wait_req(0, 10);
        n_chk++; if (req[0] !== 1'b1 || vec[0] !== 8'h49) $display("FAIL tie_second got=%b/%h exp=1/49", req[0], vec[0]); else n_pass++;
        do_ack(0);
        wait_req(0, 10);
        n_chk++; if (vec[0] !== 8'h42 || level[0] !== 5'd4) $display("FAIL tie_third got=%h/%0d exp=42/4", vec[0], level[0]); else n_pass++;
        do_ack(0);
        intreq[2] = 1'b0; intreq[7] = 1'b0; intreq[9] = 1'b0;
        repeat (4) tick();
        bus_rd(12'h080, d);
        n_chk++; if (d !== 32'd0) $display("FAIL tie_pend_clr got=%h exp=0", d); else n_pass++;
    endtask

    task automatic test_thr_target();
        bus_wr(12'h114, 32'h0001_0003);
        bus_wr(12'h804, 32'd3);
        bus_wr(12'h040, 32'h0000_0020);
        bus_wr(12'h000, 32'h0000_0020);
        intreq[5] = 1'b1;
        repeat (6) tick();
        n_chk++; if (req !== 2'b00) $display("FAIL thr_block got=%b exp=00", req); else n_pass++;
        bus_wr(12'h804, 32'd2);
        wait_req(1, 10);
        n_chk++; if (req !== 2'b10) $display("FAIL thr_req got=%b exp=10", req); else n_pass++;
        n_chk++; if (vec[1] !== 8'h45 || level[1] !== 5'd3) $display("FAIL thr_vec got=%h/%0d exp=45/3", vec[1], level[1]); else n_pass++;
        do_ack(1);
        intreq[5] = 1'b0;
        bus_rd(12'h804, d);
        n_chk++; if (d !== 32'd2) $display("FAIL thr_rd got=%h exp=2", d); else n_pass++;
    endtask

    task automatic test_nmi();
        bus_wr(12'h040, 32'h0000_0080);
        bus_wr(12'h000, 32'h0000_0080);
        intreq[7] = 1'b1;
        wait_req(0, 10);
        n_chk++; if (req[0] !== 1'b1 || vec[0] !== 8'h47) $display("FAIL nmi_pre got=%b/%h exp=1/47", req[0], vec[0]); else n_pass++;
        nmi[0] = 1'b1;
        tick();
        nmi[0] = 1'b0;
        for (int i = 0; i < 10 && level[0] !== 5'd16; i++) tick();
        n_chk++; if (level[0] !== 5'd16 || vec[0] !== 8'h0B) $display("FAIL nmi_show got=%0d/%h exp=16/0b", level[0], vec[0]); else n_pass++;
        n_chk++; if (req[0] !== 1'b1) $display("FAIL nmi_req got=%b exp=1", req[0]); else n_pass++;
        do_ack(0);
        wait_req(0, 10);
        n_chk++; if (vec[0] !== 8'h47 || level[0] !== 5'd9) $display("FAIL nmi_resume got=%h/%0d exp=47/9", vec[0], level[0]); else n_pass++;
        do_ack(0);
        intreq[7] = 1'b0;
    endtask

    task automatic test_collision();
        bus_wr(12'h110, 32'd6);
        bus_wr(12'h040, 32'h0000_0010);
        bus_wr(12'h000, 32'h0000_0010);
        bus_wr(12'h0C0, 32'h0000_0010);
        wait_req(0, 10);
        n_chk++; if (req[0] !== 1'b1 || vec[0] !== 8'h44) $display("FAIL col_sint got=%b/%h exp=1/44", req[0], vec[0]); else n_pass++;
        ack[0] = 1'b1;
        bus_wr(12'h0C0, 32'h0000_0010);
        ack[0] = 1'b0;
        n_chk++; if (req[0] !== 1'b0) $display("FAIL col_gap got=%b exp=0", req[0]); else n_pass++;
        bus_rd(12'h080, d);
        n_chk++; if (d[4] !== 1'b1) $display("FAIL col_pend_kept got=%b exp=1", d[4]); else n_pass++;
        wait_req(0, 10);
        n_chk++; if (req[0] !== 1'b1 || vec[0] !== 8'h44) $display("FAIL col_again got=%b/%h exp=1/44", req[0], vec[0]); else n_pass++;
        do_ack(0);
        bus_rd(12'h080, d);
        n_chk++; if (d[4] !== 1'b0) $display("FAIL col_pend_clr got=%b exp=0", d[4]); else n_pass++;
        intreq[10] = 1'b1;
        repeat (4) tick();
        bus_rd(12'h080, d);
        n_chk++; if (d[10] !== 1'b1) $display("FAIL lvl_pend got=%b exp=1", d[10]); else n_pass++;
        bus_wr(12'h080, 32'h0000_0400);
        bus_rd(12'h080, d);
        n_chk++; if (d[10] !== 1'b1) $display("FAIL lvl_w1c got=%b exp=1", d[10]); else n_pass++;
        bus_rd(12'h0C0, d);
        n_chk++; if (d !== 32'd0) $display("FAIL sint_rd got=%h exp=0", d); else n_pass++;
        bus_rd(12'h7F0, d);
        n_chk++; if (d !== 32'd0) $display("FAIL unmapped_rd got=%h exp=0", d); else n_pass++;
        intreq[10] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_prio_tie();
        test_thr_target();
        test_nmi();
        test_collision();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
